// File: rtl/imem_loader.sv
// imem_loader -- write side of the instruction memory used by the fetch path.
//
// The loader receives a byte stream and packs every four bytes big-endian into
// one 32-bit word. Byte 0 lands in [31:24] and byte 3 in [7:0]. It writes the
// words to consecutive word addresses starting at 0. When the programmed number
// of words has been written it raises done_o, so fetch can be released from
// reset by hardware.
//
// Handshake (in_*): a byte is transferred on a rising edge where in_valid_i and
// in_ready_o are both high. While in_valid_i is high and in_ready_o is low, the
// source holds in_data_i stable. in_ready_o depends only on the FSM state, never
// combinationally on in_valid_i.
//
// Optional feature: define IMEM_LOADER_CHECKSUM_EN to build a running
// modulo-2^32 sum of the written words on checksum_o. Without it checksum_o
// is tied to zero.
//
// Ports:
//   clk_i        clock, rising edge
//   rst_ni       asynchronous active-low reset
//   start_i      load request, honoured in IDLE or DONE only
//   load_len_i   words to load (clamped to 2^ADDR_W), sampled on accepted start
//   in_data_i    byte stream data
//   in_valid_i   byte stream valid
//   in_ready_o   loader accepts a byte this cycle (RECV state)
//   mem_we_o     one-cycle write strobe per word
//   mem_addr_o   word address, holds its last value outside a write
//   mem_wdata_o  packed word, holds its last value outside a write
//   done_o       load complete, held until the next accepted start
//   checksum_o   sum of written words (zero unless the feature is built)
//   state_o      debug view of the FSM state (0 IDLE, 1 RECV, 2 WRITE, 3 DONE)
module imem_loader #(
  parameter int ADDR_W = 8
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              start_i,
  input  logic [ADDR_W:0]   load_len_i,
  input  logic [7:0]        in_data_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [31:0]       mem_wdata_o,
  output logic              done_o,
  output logic [31:0]       checksum_o,
  output logic [1:0]        state_o
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RECV  = 2'd1,
    S_WRITE = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  localparam logic [ADDR_W:0] MAX_LEN = {1'b1, {ADDR_W{1'b0}}};

  state_e            state_q, state_d;
  logic [ADDR_W:0]   len_q, len_d;
  logic [ADDR_W:0]   word_cnt_q, word_cnt_d;
  logic [1:0]        byte_cnt_q, byte_cnt_d;
  // The first three bytes of a word. The fourth byte goes straight into mem_wdata.
  logic [23:0]       pack_q, pack_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;
  logic              start_acc;

  assign start_acc = start_i && ((state_q == S_IDLE) || (state_q == S_DONE));

  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    word_cnt_d  = word_cnt_q;
    byte_cnt_d  = byte_cnt_q;
    pack_d      = pack_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start_acc) begin
          // Clamp oversize lengths so the word counter never runs past the
          // top of memory and mem_addr never wraps.
          len_d      = (load_len_i > MAX_LEN) ? MAX_LEN : load_len_i;
          word_cnt_d = '0;
          byte_cnt_d = '0;
          pack_d     = '0;
          state_d    = (load_len_i == '0) ? S_DONE : S_RECV;
        end
      end
      S_RECV: begin
        if (in_valid_i) begin
          pack_d     = {pack_q[15:0], in_data_i};
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (byte_cnt_q == 2'd3) begin
            mem_addr_d  = word_cnt_q[ADDR_W-1:0];
            mem_wdata_d = {pack_q, in_data_i};
            state_d     = S_WRITE;
          end
        end
      end
      S_WRITE: begin
        word_cnt_d = word_cnt_q + {{ADDR_W{1'b0}}, 1'b1};
        state_d    = (word_cnt_d == len_q) ? S_DONE : S_RECV;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= S_IDLE;
      len_q       <= '0;
      word_cnt_q  <= '0;
      byte_cnt_q  <= '0;
      pack_q      <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      word_cnt_q  <= word_cnt_d;
      byte_cnt_q  <= byte_cnt_d;
      pack_q      <= pack_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign in_ready_o  = (state_q == S_RECV);
  assign mem_we_o    = (state_q == S_WRITE);
  assign done_o      = (state_q == S_DONE);
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;
  assign state_o     = state_q;

`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [31:0] checksum_q, checksum_d;

  // The sum takes in the word at the end of its WRITE cycle. So after the
  // last write it is already final when done_o rises.
  always_comb begin
    checksum_d = checksum_q;
    if (start_acc) begin
      checksum_d = '0;
    end else if (state_q == S_WRITE) begin
      checksum_d = checksum_q + mem_wdata_q;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      checksum_q <= '0;
    end else begin
      checksum_q <= checksum_d;
    end
  end

  assign checksum_o = checksum_q;
`else
  assign checksum_o = 32'h0;
`endif

endmodule

// File: tb/tb_imem_loader.sv
module tb_imem_loader;
  localparam int ADDR_W = 8;
  localparam int DEPTH  = 1 << ADDR_W;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RECV = 2'd1;

  logic              clk;
  logic              rst_n;
  logic              start;
  logic [ADDR_W:0]   load_len;
  logic [7:0]        in_data;
  logic              in_valid;
  logic              in_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              done;
  logic [31:0]       checksum;
  logic [1:0]        state;

  int checks   = 0;
  int failures = 0;
  int wr_count = 0;

  // Scoreboard: expected writes as {addr, data}, in order.
  logic [ADDR_W+31:0] exp_q[$];
  // Words to stream for the next load.
  logic [31:0]        wq[$];
  // Picture of the instruction memory built from the observed writes.
  logic [31:0]        mem_model[DEPTH];
  bit                 prev_we;

  imem_loader #(.ADDR_W(ADDR_W)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .start_i     (start),
    .load_len_i  (load_len),
    .in_data_i   (in_data),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .mem_we_o    (mem_we),
    .mem_addr_o  (mem_addr),
    .mem_wdata_o (mem_wdata),
    .done_o      (done),
    .checksum_o  (checksum),
    .state_o     (state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "simulation time limit");
  end

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endfunction

  task automatic do_reset();
    rst_n    = 1'b0;
    start    = 1'b0;
    load_len = '0;
    in_data  = '0;
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // ---------------- write monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (rst_n && mem_we) begin
      logic [ADDR_W+31:0] e;
      wr_count++;
      chk("ready_low_in_write", in_ready, 0);
      chk("we_single_cycle", prev_we, 0);
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_write actual=addr %0h data %0h required=no write", mem_addr, mem_wdata);
      end else begin
        e = exp_q.pop_front();
        chk("write_addr", mem_addr, e[ADDR_W+31:32]);
        chk("write_data", mem_wdata, e[31:0]);
      end
      mem_model[mem_addr] = mem_wdata;
    end
    prev_we = rst_n && mem_we;
  end

  // ---------------- drivers ----------------
  task automatic start_load(input logic [ADDR_W:0] len);
    @(negedge clk);
    start    = 1'b1;
    load_len = len;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Present one byte (after optional idle cycles) and hold it until accepted.
  task automatic send_byte(input logic [7:0] b, input bit gaps);
    int  idles;
    int  guard;
    bit  acc;
    idles = gaps ? int'($urandom_range(0, 3)) : 0;
    repeat (idles) begin
      @(negedge clk);
      in_valid = 1'b0;
    end
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = b;
    acc      = 1'b0;
    guard    = 0;
    while (!acc && guard < 64) begin
      if (in_ready) begin
        @(posedge clk);
        acc = 1'b1;
      end else begin
        @(posedge clk);
        @(negedge clk);
        guard++;
      end
    end
    if (!acc) begin
      checks++;
      failures++;
      $display("FAIL byte_timeout actual=not accepted required=accepted within 64 cycles");
    end
  endtask

  // start pulse while receiving: must have no effect on the running load
  task automatic poke_start();
    @(negedge clk);
    in_valid = 1'b0;
    start    = 1'b1;
    load_len = '0;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    chk("ignored_start_state", state, ST_RECV);
    chk("ignored_start_ready", in_ready, 1);
    chk("ignored_start_done", done, 0);
  endtask

  // Reference: word i of wq must appear at address i, sent as 4 bytes MSB first.
  task automatic run_load(input logic [ADDR_W:0] len, input bit gaps, input bit poke,
                          input logic [31:0] exp_sum);
    int          nwords;
    logic [31:0] es;
    logic [31:0] b32;
    nwords = (int'(len) > DEPTH) ? DEPTH : int'(len);
    for (int i = 0; i < nwords; i++) exp_q.push_back({i[ADDR_W-1:0], wq[i]});
`ifdef IMEM_LOADER_CHECKSUM_EN
    es = exp_sum;
`else
    es = 32'h0;
`endif
    start_load(len);
    @(negedge clk);
    if (nwords == 0) begin
      chk("zero_len_done", done, 1);
      chk("zero_len_ready", in_ready, 0);
      repeat (2) @(negedge clk);
    end else begin
      chk("start_ready", in_ready, 1);
      chk("start_done_clear", done, 0);
      for (int w = 0; w < nwords; w++) begin
        for (int j = 0; j < 4; j++) begin
          b32 = wq[w] >> (8 * (3 - j));
          send_byte(b32[7:0], gaps);
          if (poke && w == 0 && j == 1) poke_start();
        end
      end
      @(negedge clk);
      in_valid = 1'b0;
      chk("last_write_we", mem_we, 1);
      chk("done_not_early", done, 0);
      @(negedge clk);
    end
    chk("done_set", done, 1);
    chk("done_ready_low", in_ready, 0);
    chk("writes_drained", exp_q.size(), 0);
    chk("checksum", checksum, es);
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic [ADDR_W:0] len;
    logic [31:0]     w0;
    logic [31:0]     w1;
    logic [31:0]     w2;
    bit              gaps;
    logic [31:0]     sum;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int          wr_before;
    logic [31:0] sum;
    logic [31:0] b32;
    int          nlen;

    vecs[0] = '{len: 2, w0: 32'h00000013, w1: 32'h00400093, w2: 32'h0, gaps: 0, sum: 32'h004000A6};
    vecs[1] = '{len: 3, w0: 32'h00000013, w1: 32'h00400093, w2: 32'hDEADBEEF, gaps: 0, sum: 32'hDEEDBF95};
    vecs[2] = '{len: 3, w0: 32'h00000013, w1: 32'h00400093, w2: 32'hDEADBEEF, gaps: 1, sum: 32'hDEEDBF95};
    vecs[3] = '{len: 1, w0: 32'hFFFFFFFF, w1: 32'h0, w2: 32'h0, gaps: 1, sum: 32'hFFFFFFFF};
    vecs[4] = '{len: 0, w0: 32'h0, w1: 32'h0, w2: 32'h0, gaps: 0, sum: 32'h0};
    vecs[5] = '{len: 3, w0: 32'h80000000, w1: 32'h80000000, w2: 32'h00000001, gaps: 1, sum: 32'h00000001};

    // Reset state
    do_reset();
    chk("rst_state", state, ST_IDLE);
    chk("rst_ready", in_ready, 0);
    chk("rst_we", mem_we, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_wdata", mem_wdata, 0);
    chk("rst_done", done, 0);
    chk("rst_checksum", checksum, 0);
    in_valid = 1'b1;
    in_data  = 8'hAA;
    repeat (4) begin
      @(negedge clk);
      chk("idle_no_accept", in_ready, 0);
      chk("idle_state", state, ST_IDLE);
    end
    in_valid = 1'b0;

    // Table-driven loads
    for (int i = 0; i < 6; i++) begin
      wq.delete();
      wq.push_back(vecs[i].w0);
      wq.push_back(vecs[i].w1);
      wq.push_back(vecs[i].w2);
      run_load(vecs[i].len, vecs[i].gaps, 1'b0, vecs[i].sum);
    end

    // Ignored start in RECV, then restart from DONE at address 0
    wq.delete();
    wq.push_back(32'hCAFEF00D);
    wq.push_back(32'h12345678);
    run_load(2, 1'b0, 1'b1, 32'hDD334685);
    repeat (3) begin
      @(negedge clk);
      chk("done_held", done, 1);
    end
    wq.delete();
    wq.push_back(32'h0BADC0DE);
    run_load(1, 1'b0, 1'b0, 32'h0BADC0DE);

    // Reset in the middle of a 4-word load, after 6 bytes
    wq.delete();
    wq.push_back(32'h11111111);
    wq.push_back(32'h22222222);
    wq.push_back(32'h33333333);
    wq.push_back(32'h44444444);
    exp_q.push_back({{ADDR_W{1'b0}}, 32'h11111111});
    wr_before = wr_count;
    start_load(4);
    for (int k = 0; k < 6; k++) begin
      b32 = wq[k / 4] >> (8 * (3 - (k % 4)));
      send_byte(b32[7:0], 1'b0);
    end
    @(negedge clk);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_state", state, ST_IDLE);
    chk("midrst_ready", in_ready, 0);
    chk("midrst_done", done, 0);
    chk("midrst_we", mem_we, 0);
    chk("midrst_checksum", checksum, 0);
    chk("midrst_writes", wr_count - wr_before, 1);
    chk("midrst_drained", exp_q.size(), 0);
    chk("midrst_mem0", mem_model[0], 32'h11111111);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    wq.delete();
    wq.push_back(32'h5A5AA5A5);
    run_load(1, 1'b0, 1'b0, 32'h5A5AA5A5);
    chk("rewrite_mem0", mem_model[0], 32'h5A5AA5A5);

    // Randomized loads against the word-list model
    for (int r = 0; r < 6; r++) begin
      nlen = int'($urandom_range(1, 6));
      wq.delete();
      sum = 32'h0;
      for (int i = 0; i < nlen; i++) begin
        wq.push_back($urandom);
        sum = sum + wq[i];
      end
      run_load(nlen[ADDR_W:0], 1'($urandom_range(0, 1)), 1'b0, sum);
    end

    // Oversize length: clamped to the full memory, top address written last
    wq.delete();
    sum = 32'h0;
    for (int i = 0; i < DEPTH; i++) begin
      wq.push_back($urandom);
      sum = sum + wq[i];
    end
    run_load({(ADDR_W+1){1'b1}}, 1'b0, 1'b0, sum);
    chk("clamp_last_addr", mem_addr, DEPTH - 1);
    chk("clamp_top_word", mem_model[DEPTH-1], wq[DEPTH-1]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
